cache_arbiter: RTL

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/cache_arbiter.sv
// Two-master round-robin arbiter in front of a single-port cache.
// Holds cache inputs stable from grant until the next grant.
module cache_arbiter #(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_wr,
    input  logic        m1_wr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic        m0_err,
    output logic        m1_err,
    output logic [31:0] rdata,
    output logic [31:0] c_data,
    output logic [31:0] c_addr,
    output logic        c_wr,
    input  logic        c_state,
    input  logic [31:0] c_q
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [7:0] SETTLE_V = 8'(SETTLE);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic       gnt;
    logic       prio;
    logic       err_q;
    logic [7:0] scnt;
    logic [7:0] wcnt;
    logic       pick;

    // prio=0 favours m0; a lone request wins regardless
    always_comb begin
        pick = m1_req && (!m0_req || prio);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt    <= 1'b0;
            prio   <= 1'b0;
            err_q  <= 1'b0;
            scnt   <= 8'd0;
            wcnt   <= 8'd0;
            rdata  <= 32'd0;
            c_data <= 32'd0;
            c_addr <= 32'd0;
            c_wr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gnt    <= pick;
                        prio   <= ~pick;
                        c_wr   <= pick ? m1_wr : m0_wr;
                        c_addr <= pick ? m1_addr : m0_addr;
                        c_data <= pick ? m1_wdata : m0_wdata;
                        scnt   <= SETTLE_V;
                        wcnt   <= 8'd0;
                        err_q  <= 1'b0;
                        state  <= (SETTLE_V == 8'd0) ? WAIT : ISSUE;
                    end
                end
                ISSUE: begin
                    scnt <= scnt - 8'd1;
                    if (scnt <= 8'd1) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (c_state) begin
                        if (!c_wr) begin
                            rdata <= c_q;
                        end
                        state <= RESP;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                        if (wcnt == TO_LAST) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign m0_ack = (state == RESP) && !gnt;
    assign m1_ack = (state == RESP) && gnt;
    assign m0_err = m0_ack && err_q;
    assign m1_err = m1_ack && err_q;

endmodule
